// File: rtl/fifo_fwft_read_stage_pkg.sv
// Shared definitions for the FWFT read stage: buffer occupancy encoding,
// default word width and statistics counter width.
package fifo_fwft_read_stage_pkg;

    typedef enum logic [1:0] {
        CNT_ZERO = 2'd0,
        CNT_ONE  = 2'd1,
        CNT_TWO  = 2'd2
    } cnt_e;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int STATS_CNT_W        = 16;

endpackage

// File: rtl/fwft_skid_buf.sv
// Two-entry output buffer. buf0 is always the head; a pop shifts buf1 forward
// in the same edge a new word is captured, so arrival order is preserved.
module fwft_skid_buf
    import fifo_fwft_read_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output cnt_e                  count_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    cnt_e                  count_q, count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    always_comb begin
        count_d = count_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (count_q)
            CNT_ZERO: begin
                if (push_i) begin
                    buf0_d  = push_data_i;
                    count_d = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push_i && pop_i) begin
                    buf0_d = push_data_i;
                end else if (push_i) begin
                    buf1_d  = push_data_i;
                    count_d = CNT_TWO;
                end else if (pop_i) begin
                    count_d = CNT_ZERO;
                end
            end
            CNT_TWO: begin
                // The issue rule never lets a word arrive into a full buffer
                // unless the head is leaving in the same cycle.
                if (pop_i) begin
                    buf0_d = buf1_q;
                    if (push_i) begin
                        buf1_d = push_data_i;
                    end else begin
                        count_d = CNT_ONE;
                    end
                end
            end
            default: begin
                count_d = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_ZERO;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            count_q <= count_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != CNT_ZERO);
    assign head_o  = buf0_q;

endmodule

// File: rtl/fifo_fwft_read_stage.sv
// First-word-fall-through read stage of the async FIFO (read clock domain).
// Optional statistics outputs are enabled with `define FWFT_RD_STATS_EN.
module fifo_fwft_read_stage
    import fifo_fwft_read_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int RAM_LATENCY = 1
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   empty,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  rdata,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data
`ifdef FWFT_RD_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0] rd_count,
    output logic                   stall_seen
`endif
);

    generate
        if (RAM_LATENCY != 1) begin : g_bad_ram_latency
            $error("fifo_fwft_read_stage: RAM_LATENCY must be 1");
        end
    endgenerate

    cnt_e       count;
    logic       pop;
    logic       inflight_q, inflight_d;
    logic [2:0] occ_next;

    assign pop = m_valid & m_ready;

    // Occupancy after this edge if nothing new is issued; rd_en may only fire
    // when that leaves room for the word it requests. This makes m_ready a
    // combinational input to rd_en by design.
    assign occ_next   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en      = ~rrst & ~empty & (occ_next <= 3'd1);
    assign inflight_d = rd_en;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fwft_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (rclk),
        .rst         (rrst),
        .push_i      (inflight_q),
        .push_data_i (rdata),
        .pop_i       (pop),
        .count_o     (count),
        .valid_o     (m_valid),
        .head_o      (m_data)
    );

`ifdef FWFT_RD_STATS_EN
    logic [STATS_CNT_W-1:0] rd_count_q, rd_count_d;
    logic                   stall_seen_q, stall_seen_d;

    always_comb begin
        rd_count_d   = rd_count_q;
        stall_seen_d = stall_seen_q | (m_valid & ~m_ready);
        if (pop && (rd_count_q != {STATS_CNT_W{1'b1}})) begin
            rd_count_d = rd_count_q + STATS_CNT_W'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_count_q   <= '0;
            stall_seen_q <= 1'b0;
        end else begin
            rd_count_q   <= rd_count_d;
            stall_seen_q <= stall_seen_d;
        end
    end

    assign rd_count   = rd_count_q;
    assign stall_seen = stall_seen_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_read_stage.sv
// Bench for fifo_fwft_read_stage: queue-based reference model with a per-cycle
// compare process, a RAM stand-in serving sequential words, and directed scenarios.
module tb_fifo_fwft_read_stage;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rrst = 1'b1;
    logic         empty = 1'b1;
    logic         m_ready = 1'b0;
    logic [W-1:0] rdata = '0;
    logic         rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
`ifdef FWFT_RD_STATS_EN
    logic [15:0]  rd_count;
    logic         stall_seen;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_fwft_read_stage #(
        .DATA_WIDTH  (W),
        .RAM_LATENCY (1)
    ) dut (
        .rclk       (clk),
        .rrst       (rrst),
        .empty      (empty),
        .rd_en      (rd_en),
        .rdata      (rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FWFT_RD_STATS_EN
        ,
        .rd_count   (rd_count),
        .stall_seen (stall_seen)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words buffered for the consumer, in order, plus the one
    // requested last cycle and still coming out of the RAM.
    logic [W-1:0] exp_q[$];
    bit           m_infl = 1'b0;
    logic [W-1:0] m_infl_word = '0;
    logic [W-1:0] m_ptr = '0;
    logic [15:0]  m_rd_cnt = '0;
    bit           m_stall = 1'b0;
    int           pops_total = 0;
    bit           chk_en = 1'b0;

    // RAM stand-in: serves ram_ptr, ram_ptr+1, ... on the DUT's own rd_en.
    logic [W-1:0] ram_base = '0;
    logic [W-1:0] ram_ptr = '0;
    logic [W-1:0] ram_next = '0;

    always @(posedge clk) begin
        #1;
        rdata = ram_next;
    end

    always @(negedge clk) begin
        bit exp_valid;
        bit pop;
        bit exp_rd;
        int occ;
        if (rrst) begin
            if (chk_en) check("rd_en_in_reset", rd_en, 0);
            exp_q.delete();
            m_infl   = 1'b0;
            m_ptr    = ram_base;
            ram_ptr  = ram_base;
            ram_next = W'($urandom);
            m_rd_cnt = '0;
            m_stall  = 1'b0;
        end else if (chk_en) begin
            exp_valid = (exp_q.size() != 0);
            pop       = exp_valid && m_ready;
            occ       = exp_q.size() + int'(m_infl) - int'(pop);
            exp_rd    = !empty && (occ <= 1);
            check("m_valid", m_valid, exp_valid);
            if (exp_valid) check("m_data", m_data, exp_q[0]);
            check("rd_en", rd_en, exp_rd);
            check("rd_en_while_empty", rd_en & empty, 0);
            check("count", dut.u_buf.count_o, exp_q.size());
            check("count_le_2", dut.u_buf.count_o <= 2, 1);
`ifdef FWFT_RD_STATS_EN
            check("rd_count", rd_count, m_rd_cnt);
            check("stall_seen", stall_seen, m_stall);
`endif
            if (pop) begin
                void'(exp_q.pop_front());
                pops_total++;
                if (m_rd_cnt != 16'hFFFF) m_rd_cnt++;
            end
            if (exp_valid && !m_ready) m_stall = 1'b1;
            if (m_infl) exp_q.push_back(m_infl_word);
            m_infl = exp_rd;
            if (exp_rd) begin
                m_infl_word = m_ptr;
                m_ptr++;
            end
            if (rd_en) begin
                ram_next = ram_ptr;
                ram_ptr++;
            end else begin
                ram_next = W'($urandom);
            end
        end
    end

    task automatic cyc(input bit e, input bit r, input bit rst);
        @(posedge clk);
        #1;
        empty   = e;
        m_ready = r;
        rrst    = rst;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [W-1:0] base);
        ram_base = base;
        cyc(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int first;
        int npop;
        int pulses;
        int target;
        int guard;

        do_reset(8'h00);
        chk_en = 1'b1;

        // idle after reset: nothing may be issued or presented
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            check("idle_rd_en", rd_en, 0);
            check("idle_m_valid", m_valid, 0);
            check("idle_m_data", m_data, 0);
        end

        // single word: request in cycle 5, visible in cycle 7 only
        do_reset(8'hA5);
        for (int i = 0; i < 12; i++) begin
            cyc(i != 5, 1'b1, 1'b0);
            check("single_rd_en", rd_en, i == 5);
            check("single_m_valid", m_valid, i == 7);
            if (i == 7) check("single_m_data", m_data, 8'hA5);
        end

        // streaming: one word per cycle, two cycles after the first request
        do_reset(8'h00);
        first = -1;
        npop  = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (rd_en && first < 0) first = i;
            if (m_valid) begin
                if (npop < 16) begin
                    check("stream_cycle", i, first + 2 + npop);
                    check("stream_data", m_data, npop);
                end
                npop++;
            end
        end
        check("stream_first_rd", first, 0);
        check("stream_enough_words", npop >= 16, 1);

        // backpressure: exactly two requests fill the buffer, then hold
        do_reset(8'h00);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            pulses += int'(rd_en);
        end
        check("bp_pulses", pulses, 2);
        check("bp_count", dut.u_buf.count_o, 2);
        check("bp_head", m_data, 8'h00);
        check("bp_m_valid", m_valid, 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("bp_resume_rd_en", rd_en, 1);
        check("bp_resume_pop", m_valid, 1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);

        // random traffic until 1000 further words reach the consumer
        do_reset(8'h10);
        target = pops_total + 1000;
        guard  = 0;
        while (pops_total < target && guard < 20000) begin
            cyc($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        check("random_done", pops_total >= target, 1);

        // reset one cycle after a request: the in-flight word is dropped
        do_reset(8'h40);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        check("rst_rd_en_before", rd_en, 1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        check("rst_m_valid_after", m_valid, 0);
`ifdef FWFT_RD_STATS_EN
        check("rst_rd_count", rd_count, 0);
        check("rst_stall_seen", stall_seen, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            check("rst_no_stray_word", m_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_read_stage.md
Name: fifo_fwft_read_stage

Overview:
- Read-side output stage of the async FIFO, in the read clock domain, directly downstream of the read pointer handler and the dual-port RAM read port.
- Consumes `empty` and the RAM read data. Drives `rd_en` so the pointer advances only when a slot is guaranteed free.
- Presents a first-word-fall-through valid/ready stream to the consumer.
- Sustains one word per cycle through a 2-entry output buffer that absorbs the RAM's 1-cycle read latency.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word.
- RAM_LATENCY, 1, rclk cycles from rd_en to valid rdata; only value 1 is supported, anything else is an elaboration error.

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  synchronous, active-high reset, sampled on posedge rclk.
- empty  input  1  from the read pointer handler; 1 = no unread word.
- rd_en  output  1  to the read pointer handler and RAM read enable; combinational.
- rdata  input  DATA_WIDTH  RAM read data, valid in the cycle after a cycle with rd_en=1.
- m_valid  output  1  stream word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  DATA_WIDTH  stream word (head of buffer).

Behaviour:
- One clock, rclk. Reset is synchronous and active-high. All state updates on posedge rclk.
- State: `count` 0..2 (buffered words), `inflight` 1 bit (read issued last cycle), `buf0` (head), `buf1`.
- FSM on count:
  - ZERO, ONE, TWO.
  - Next count = count + inflight − pop, where pop = m_valid & m_ready.
- m_valid = (count != 0). m_data = buf0, registered and stable while m_valid=1 and m_ready=0.
- Issue rule:
  - rd_en = ~empty & ((count + inflight − pop) <= 1).
  - Guarantees no overflow even when the consumer stalls indefinitely.
  - rd_en is never asserted while empty=1.
- inflight <= rd_en every cycle.
- Capture when inflight=1: rdata is written to the lowest free slot after the pop shift.
  - If buf0 was popped, buf1 moves to buf0 in the same edge, so arrival order is preserved.
  - Arrival and pop in the same cycle: count unchanged, new word lands behind the surviving word.
- Latency: rd_en in cycle t → rdata in t+1 → m_valid=1 in t+2.
  - With m_ready held high and empty=0, steady state is one transfer per cycle (count=1, inflight=1).
- Stall: a full buffer (count=2, inflight=0) holds rd_en=0 until a pop occurs.
- Combinational path m_ready → rd_en is intentional and documented for timing.
- Reset values:
  - count=0, inflight=0, m_valid=0, rd_en=0 during the reset cycle.
  - buf0/buf1=0, so m_data=0.
- Reset mid-operation:
  - In-flight data arriving the cycle after reset is discarded.
  - The pointer handler is reset on the same FIFO-level reset, so no word accounting survives.
- Reordering or duplication of words is a hard failure.

Optional Feature:
- Macro FWFT_RD_STATS_EN.
- When defined:
  - Adds output `rd_count` (16 bits), counting completed stream transfers (pop); saturates at 16'hFFFF and cleared by rrst.
  - Adds output `stall_seen` (1 bit), a sticky flag set when m_valid=1 & m_ready=0; cleared only by rrst.
- When undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared FIFO package:
  - count state encoding constants (CNT_ZERO/CNT_ONE/CNT_TWO, 2-bit).
  - Default DATA_WIDTH.
  - The stats counter width constant (16).
- One sub-module is natural: fwft_skid_buf (2-entry buffer with shift/capture and count).
- Issue logic and inflight stay in the top.

Test Plan:
- Reset then empty=1 for 10 cycles → rd_en=0, m_valid=0, m_data=0 throughout.
- Single word: empty falls at cycle 5 with rdata=8'hA5 next cycle, m_ready=1 → rd_en=1 in cycle 5 only; m_valid=1 and m_data=8'hA5 in cycle 7 only.
- Streaming 16 words 0x00..0x0F, empty=0, m_ready=1 → one word per cycle in order, starting 2 cycles after the first rd_en; no gaps.
- Backpressure: m_ready=0 while empty=0 → exactly 2 rd_en pulses, then rd_en=0; count=2, m_data holds the first word. Release m_ready → words drain in order, rd_en resumes in the same cycle as the first pop.
- Random m_ready (50%) and random empty over 1000 words → scoreboard exact order; rd_en never high with empty=1; count never exceeds 2.
- rrst asserted one cycle after an rd_en → in-flight word discarded; m_valid=0 next cycle; with FWFT_RD_STATS_EN, rd_count=0 and stall_seen=0.
